// File: rtl/id_ex_operand_stage.sv
// rtl/id_ex_operand_stage.sv - ID/EX operand register with EX/MEM/WB forwarding and load-use stall
// Resolves three source operands per cycle and registers them with the decoded control word.
module id_ex_operand_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int CTRL_W = 16,
   parameter int PC_REG = 15
) (
   input  logic              Clk,
   input  logic              R,
   input  logic              id_valid,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic [REG_AW-1:0] ra,
   input  logic [REG_AW-1:0] rb,
   input  logic [REG_AW-1:0] rc,
   input  logic [2:0]        id_use,
   input  logic [DATA_W-1:0] pa,
   input  logic [DATA_W-1:0] pb,
   input  logic [DATA_W-1:0] pc,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_we,
   input  logic              id_is_load,
   input  logic [DATA_W-1:0] ex_result,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_we,
   input  logic              mem_is_load,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_dvalid,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_we,
   input  logic [DATA_W-1:0] wb_data,
   input  logic              flush,
   input  logic              ex_hold,
   output logic              ex_valid,
   output logic [CTRL_W-1:0] ex_ctrl,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [DATA_W-1:0] ex_c,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_we,
   output logic              ex_is_load,
   output logic              stall_id
);

   localparam logic [REG_AW-1:0] PC_IDX = REG_AW'(PC_REG);

   logic              ex_valid_q, ex_valid_d;
   logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
   logic [DATA_W-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_c_q, ex_c_d;
   logic [REG_AW-1:0] ex_rd_q, ex_rd_d;
   logic              ex_we_q, ex_we_d;
   logic              ex_is_load_q, ex_is_load_d;

   logic [REG_AW-1:0] src [3];
   logic [DATA_W-1:0] rf  [3];
   logic [DATA_W-1:0] opnd [3];
   logic [2:0]        chk;
   logic              load_use;

   // An EX-stage load has no result yet, so it is skipped here and caught by load_use instead.
   always_comb begin
      src[0] = ra;
      src[1] = rb;
      src[2] = rc;
      rf[0]  = pa;
      rf[1]  = pb;
      rf[2]  = pc;
      opnd   = '{default: '0};
      chk    = '0;
      load_use = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk[i] = id_use[i] && (src[i] != PC_IDX);
         if (!chk[i])
            opnd[i] = rf[i];
         else if (ex_valid_q && ex_we_q && !ex_is_load_q && (ex_rd_q == src[i]))
            opnd[i] = ex_result;
         else if (mem_we && mem_dvalid && (mem_rd == src[i]))
            opnd[i] = mem_data;
         else if (wb_we && (wb_rd == src[i]))
            opnd[i] = wb_data;
         else
            opnd[i] = rf[i];
         if (id_valid && chk[i] &&
             ((ex_valid_q && ex_we_q && ex_is_load_q && (ex_rd_q == src[i])) ||
              (mem_we && mem_is_load && !mem_dvalid && (mem_rd == src[i]))))
            load_use = 1'b1;
      end
   end

   assign stall_id = load_use | ex_hold;

   always_comb begin
      ex_valid_d   = ex_valid_q;
      ex_ctrl_d    = ex_ctrl_q;
      ex_a_d       = ex_a_q;
      ex_b_d       = ex_b_q;
      ex_c_d       = ex_c_q;
      ex_rd_d      = ex_rd_q;
      ex_we_d      = ex_we_q;
      ex_is_load_d = ex_is_load_q;
      if (flush) begin
         ex_valid_d = 1'b0;
         ex_we_d    = 1'b0;
      end else if (ex_hold) begin
         ex_valid_d = ex_valid_q;
      end else if (load_use) begin
         ex_valid_d   = 1'b0;
         ex_we_d      = 1'b0;
         ex_is_load_d = 1'b0;
      end else begin
         ex_valid_d   = id_valid;
         ex_ctrl_d    = id_ctrl;
         ex_a_d       = opnd[0];
         ex_b_d       = opnd[1];
         ex_c_d       = opnd[2];
         ex_rd_d      = id_rd;
         ex_we_d      = id_we & id_valid;
         ex_is_load_d = id_is_load;
      end
   end

   always_ff @(posedge Clk or negedge R) begin
      if (!R) begin
         ex_valid_q   <= 1'b0;
         ex_ctrl_q    <= '0;
         ex_a_q       <= '0;
         ex_b_q       <= '0;
         ex_c_q       <= '0;
         ex_rd_q      <= '0;
         ex_we_q      <= 1'b0;
         ex_is_load_q <= 1'b0;
      end else begin
         ex_valid_q   <= ex_valid_d;
         ex_ctrl_q    <= ex_ctrl_d;
         ex_a_q       <= ex_a_d;
         ex_b_q       <= ex_b_d;
         ex_c_q       <= ex_c_d;
         ex_rd_q      <= ex_rd_d;
         ex_we_q      <= ex_we_d;
         ex_is_load_q <= ex_is_load_d;
      end
   end

   assign ex_valid   = ex_valid_q;
   assign ex_ctrl    = ex_ctrl_q;
   assign ex_a       = ex_a_q;
   assign ex_b       = ex_b_q;
   assign ex_c       = ex_c_q;
   assign ex_rd      = ex_rd_q;
   assign ex_we      = ex_we_q;
   assign ex_is_load = ex_is_load_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb/tb_id_ex_operand_stage.sv - directed scenario bench for id_ex_operand_stage
// Each task drives one scenario and checks its expected values inline.
module tb_id_ex_operand_stage;

   logic        Clk = 1'b0;
   logic        R;
   logic        id_valid;
   logic [15:0] id_ctrl;
   logic [3:0]  ra, rb, rc, id_rd, mem_rd, wb_rd;
   logic [2:0]  id_use;
   logic [31:0] pa, pb, pc, ex_result, mem_data, wb_data;
   logic        id_we, id_is_load, mem_we, mem_is_load, mem_dvalid, wb_we, flush, ex_hold;
   logic        ex_valid, ex_we, ex_is_load, stall_id;
   logic [15:0] ex_ctrl;
   logic [31:0] ex_a, ex_b, ex_c;
   logic [3:0]  ex_rd;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 Clk = ~Clk;

   id_ex_operand_stage dut (
      .Clk(Clk), .R(R), .id_valid(id_valid), .id_ctrl(id_ctrl),
      .ra(ra), .rb(rb), .rc(rc), .id_use(id_use), .pa(pa), .pb(pb), .pc(pc),
      .id_rd(id_rd), .id_we(id_we), .id_is_load(id_is_load), .ex_result(ex_result),
      .mem_rd(mem_rd), .mem_we(mem_we), .mem_is_load(mem_is_load), .mem_data(mem_data),
      .mem_dvalid(mem_dvalid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data),
      .flush(flush), .ex_hold(ex_hold), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
      .ex_a(ex_a), .ex_b(ex_b), .ex_c(ex_c), .ex_rd(ex_rd), .ex_we(ex_we),
      .ex_is_load(ex_is_load), .stall_id(stall_id)
   );

   task automatic idle();
      id_valid = 0; id_ctrl = '0; ra = 0; rb = 0; rc = 0; id_use = 0;
      pa = 0; pb = 0; pc = 0; id_rd = 0; id_we = 0; id_is_load = 0;
      ex_result = 0; mem_rd = 0; mem_we = 0; mem_is_load = 0; mem_data = 0;
      mem_dvalid = 0; wb_rd = 0; wb_we = 0; wb_data = 0; flush = 0; ex_hold = 0;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Decode a writing instruction into EX so later decodes can hit it.
   task automatic put_in_ex(input logic [3:0] rd, input logic ld);
      idle();
      id_valid = 1; id_rd = rd; id_we = 1; id_is_load = ld; id_ctrl = 16'hA5A5;
      tick();
   endtask

   task automatic test_reset();
      idle();
      R = 0;
      #12;
      total_cnt++;
      if ({ex_valid, ex_we, ex_is_load, ex_ctrl, ex_a, ex_b, ex_c, ex_rd} !== '0)
         $display("FAIL reset_outputs: got %h required 0",
                  {ex_valid, ex_we, ex_is_load, ex_ctrl, ex_a, ex_b, ex_c, ex_rd});
      else pass_cnt++;
      total_cnt++;
      if (stall_id !== 1'b0) $display("FAIL reset_stall: got %b required 0", stall_id);
      else pass_cnt++;
      @(negedge Clk);
      R = 1;
      tick();
   endtask

   task automatic test_ex_forward();
      put_in_ex(4'd3, 1'b0);
      total_cnt++;
      if (ex_ctrl !== 16'hA5A5 || ex_rd !== 4'd3 || ex_we !== 1'b1)
         $display("FAIL capture_ctrl: got %h/%h/%b required a5a5/3/1", ex_ctrl, ex_rd, ex_we);
      else pass_cnt++;
      idle();
      id_valid = 1; ra = 3; id_use = 3'b001; pa = 32'h5; ex_result = 32'h10; id_rd = 6;
      tick();
      total_cnt++;
      if (ex_a !== 32'h10) $display("FAIL ex_forward: got %h required 00000010", ex_a);
      else pass_cnt++;
   endtask

   task automatic test_priority();
      put_in_ex(4'd2, 1'b0);
      idle();
      id_valid = 1; rb = 2; id_use = 3'b010; pb = 32'hDEAD; id_rd = 2; id_we = 0;
      ex_result = 32'hA; mem_rd = 2; mem_we = 1; mem_dvalid = 1; mem_data = 32'hB;
      wb_rd = 2; wb_we = 1; wb_data = 32'hC;
      tick();
      total_cnt++;
      if (ex_b !== 32'hA) $display("FAIL prio_ex: got %h required 0000000a", ex_b);
      else pass_cnt++;
      total_cnt++;
      if (ex_we !== 1'b0) $display("FAIL ex_we_cleared: got %b required 0", ex_we);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ex_b !== 32'hB) $display("FAIL prio_mem: got %h required 0000000b", ex_b);
      else pass_cnt++;
      mem_dvalid = 0; mem_is_load = 0;
      tick();
      total_cnt++;
      if (ex_b !== 32'hC) $display("FAIL prio_wb: got %h required 0000000c", ex_b);
      else pass_cnt++;
      wb_we = 0;
      tick();
      total_cnt++;
      if (ex_b !== 32'hDEAD) $display("FAIL prio_rf: got %h required 0000dead", ex_b);
      else pass_cnt++;
   endtask

   task automatic test_load_use();
      put_in_ex(4'd4, 1'b1);
      idle();
      rc = 4; id_use = 3'b100; pc = 32'h1; id_rd = 5; id_we = 1;
      #1;
      total_cnt++;
      if (stall_id !== 1'b0) $display("FAIL bubble_no_stall: got %b required 0", stall_id);
      else pass_cnt++;
      id_valid = 1;
      #1;
      total_cnt++;
      if (stall_id !== 1'b1) $display("FAIL load_use_stall: got %b required 1", stall_id);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ex_valid !== 1'b0 || ex_we !== 1'b0 || ex_is_load !== 1'b0)
         $display("FAIL load_use_bubble: got %b%b%b required 000", ex_valid, ex_we, ex_is_load);
      else pass_cnt++;
      mem_rd = 4; mem_we = 1; mem_is_load = 1; mem_dvalid = 0; mem_data = 32'h77;
      #1;
      total_cnt++;
      if (stall_id !== 1'b1) $display("FAIL mem_load_wait_stall: got %b required 1", stall_id);
      else pass_cnt++;
      mem_dvalid = 1;
      #1;
      total_cnt++;
      if (stall_id !== 1'b0) $display("FAIL mem_load_ready_stall: got %b required 0", stall_id);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ex_c !== 32'h77 || ex_valid !== 1'b1 || ex_we !== 1'b1)
         $display("FAIL load_forward: got %h v=%b we=%b required 00000077 v=1 we=1",
                  ex_c, ex_valid, ex_we);
      else pass_cnt++;
   endtask

   task automatic test_pc_and_wb();
      put_in_ex(4'd15, 1'b0);
      idle();
      id_valid = 1; ra = 15; rb = 7; rc = 15; id_use = 3'b011;
      pa = 32'h1234; pb = 32'h11; pc = 32'h2222; ex_result = 32'hBAD;
      wb_rd = 7; wb_we = 1; wb_data = 32'h99; id_rd = 1; id_we = 1;
      tick();
      total_cnt++;
      if (ex_a !== 32'h1234) $display("FAIL pc_no_forward: got %h required 00001234", ex_a);
      else pass_cnt++;
      total_cnt++;
      if (ex_b !== 32'h99) $display("FAIL wb_write_through: got %h required 00000099", ex_b);
      else pass_cnt++;
      idle();
      id_valid = 1; rc = 1; id_use = 3'b000; pc = 32'h3333; ex_result = 32'h4444;
      tick();
      total_cnt++;
      if (ex_c !== 32'h3333) $display("FAIL unused_source: got %h required 00003333", ex_c);
      else pass_cnt++;
   endtask

   task automatic test_hold_flush();
      idle();
      id_valid = 1; ra = 9; id_use = 3'b001; pa = 32'h1234; id_rd = 8; id_we = 1;
      tick();
      pa = 32'h5555; ex_hold = 1;
      #1;
      total_cnt++;
      if (stall_id !== 1'b1) $display("FAIL hold_stall: got %b required 1", stall_id);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (ex_a !== 32'h1234 || ex_valid !== 1'b1 || ex_rd !== 4'd8)
         $display("FAIL hold_keep: got %h v=%b rd=%h required 00001234 v=1 rd=8",
                  ex_a, ex_valid, ex_rd);
      else pass_cnt++;
      put_in_ex(4'd4, 1'b1);
      idle();
      id_valid = 1; rc = 4; id_use = 3'b100; id_we = 1; ex_hold = 1; flush = 1;
      tick();
      total_cnt++;
      if (ex_valid !== 1'b0 || ex_we !== 1'b0)
         $display("FAIL flush_override: got v=%b we=%b required v=0 we=0", ex_valid, ex_we);
      else pass_cnt++;
   endtask

   task automatic test_mid_reset();
      put_in_ex(4'd6, 1'b0);
      R = 0;
      #1;
      total_cnt++;
      if (ex_valid !== 1'b0 || ex_rd !== 4'd0 || ex_we !== 1'b0)
         $display("FAIL async_reset: got v=%b rd=%h we=%b required 0/0/0", ex_valid, ex_rd, ex_we);
      else pass_cnt++;
      @(negedge Clk);
      R = 1;
      idle();
      id_valid = 1; ra = 6; id_use = 3'b001; pa = 32'h60; ex_result = 32'hBEEF;
      tick();
      total_cnt++;
      if (ex_a !== 32'h60) $display("FAIL no_stale_forward: got %h required 00000060", ex_a);
      else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_ex_forward();
      test_priority();
      test_load_use();
      test_pc_and_wb();
      test_hold_flush();
      test_mid_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
